// File: rtl/sat_accum_seq_pkg.sv
// Shared definitions for the saturating burst accumulator: FSM encoding and
// saturation limits as functions of the data width.
package sat_accum_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement bit patterns; callers truncate to their width.
    function automatic logic [63:0] max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] max_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_accum_seq_sumador.sv
// Combinational saturating adder (the shared "sumador"): clamps to the
// representable range instead of wrapping. Also exports the raw sum sign bit.
module sat_accum_seq_sumador
    import sat_accum_seq_pkg::*;
#(
    parameter int size = 22,
    parameter bit sign = 1'b1
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic [size-1:0] res,
    output logic            raw_msb
);

    generate
        if (sign) begin : g_signed
            logic [size-1:0] raw;
            logic            pos_ovf;
            logic            neg_ovf;

            assign raw     = a + b;
            assign raw_msb = raw[size-1];
            assign pos_ovf = ~a[size-1] & ~b[size-1] &  raw[size-1];
            assign neg_ovf =  a[size-1] &  b[size-1] & ~raw[size-1];
            assign res     = pos_ovf ? size'(max_pos(size)) :
                             neg_ovf ? size'(max_neg(size)) : raw;
        end else begin : g_unsigned
            logic [size:0] wide;

            assign wide    = {1'b0, a} + {1'b0, b};
            assign raw_msb = wide[size-1];
            assign res     = wide[size] ? {size{1'b1}} : wide[size-1:0];
        end
    endgenerate

endmodule

// File: rtl/sat_accum_seq.sv
// Burst accumulator: sums N_TERMS signed samples through one saturating adder,
// saturating at every step, and hands the result to a valid/ready consumer.
module sat_accum_seq
    import sat_accum_seq_pkg::*;
#(
    parameter int W       = 22,
    parameter int N_TERMS = 4,
    parameter int CW      = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] acc_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         sat_flag
);

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  acc;
    logic [W-1:0]  sum_sat;
    logic          sum_msb;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          last;
    logic          take;
    logic          clear;
    logic          release_out;

    sat_accum_seq_sumador #(
        .size (W),
        .sign (1'b1)
    ) u_sumador (
        .a       (acc),
        .b       (in_data),
        .res     (sum_sat),
        .raw_msb (sum_msb)
    );

    // Overflow: operands share a sign that the unclamped sum does not.
    assign ovf      = (acc[W-1] == in_data[W-1]) && (sum_msb != acc[W-1]);
    assign last     = (cnt == CW'(N_TERMS - 1));
    assign in_ready = (state == ACC);
    assign busy     = (state != IDLE);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        take        = 1'b0;
        clear       = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = ACC;
                end
            end
            ACC: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (in_valid) begin
                    take = 1'b1;
                    if (last) state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and an async reset in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            if (clear) begin
                acc      <= '0;
                cnt      <= '0;
                sat_flag <= 1'b0;
            end
            if (take) begin
                acc      <= sum_sat;
                cnt      <= cnt + 1'b1;
                sat_flag <= sat_flag | ovf;
                if (last) begin
                    acc_out   <= sum_sat;
                    out_valid <= 1'b1;
                end
            end
            if (release_out) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sat_accum_seq.sv
// Scenario bench for sat_accum_seq: expected burst results are queued as terms
// are driven and compared when the DUT presents out_valid.
module tb_sat_accum_seq;

    localparam int W       = 22;
    localparam int N_TERMS = 4;
    localparam int CW      = 3;

    typedef logic [W-1:0] terms_t [N_TERMS];
    typedef struct {
        logic [W-1:0] acc;
        logic         sat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] acc_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         sat_flag;

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    sat_accum_seq #(.W(W), .N_TERMS(N_TERMS), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    // Reference step: exact wide sum, then clamp to the W-bit signed range.
    task automatic model_add(inout logic [W-1:0] a, input logic [W-1:0] b, inout logic sat);
        longint s;
        longint lmax;
        longint lmin;
        lmax = (longint'(1) <<< (W - 1)) - 1;
        lmin = -(longint'(1) <<< (W - 1));
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > lmax) begin
            s = lmax;
            sat = 1'b1;
        end else if (s < lmin) begin
            s = lmin;
            sat = 1'b1;
        end
        a = W'(s);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_enters_acc: busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
    endtask

    task automatic drive_term(input logic [W-1:0] d);
        bit ok = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL term_accept: term %h not accepted within 20 cycles", d);
        end
    endtask

    task automatic run_burst(input terms_t t, input int gap);
        logic [W-1:0] e_acc = '0;
        logic         e_sat = 1'b0;
        do_start();
        for (int i = 0; i < N_TERMS; i++) begin
            if (i > 0) repeat (gap) cycle();
            drive_term(t[i]);
            model_add(e_acc, t[i], e_sat);
        end
        sb.push_back('{acc: e_acc, sat: e_sat});
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_latency: out_valid=%b one cycle after last term, expected 1", out_valid);
        end
    endtask

    task automatic collect(input string name);
        exp_t e;
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) cycle();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b after 50 cycles, expected 1", name, out_valid);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: out_valid=1 with no expected result queued", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (acc_out !== e.acc) begin
                errors++;
                $display("FAIL %s_acc: acc_out=%h expected %h", name, acc_out, e.acc);
            end
            checks++;
            if (sat_flag !== e.sat) begin
                errors++;
                $display("FAIL %s_sat: sat_flag=%b expected %b", name, sat_flag, e.sat);
            end
        end
    endtask

    task automatic expect_idle_after_handshake(input string name);
        cycle();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b busy=%b in_ready=%b expected 0 0 0",
                     name, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) cycle();
        checks++;
        if ({acc_out, out_valid, sat_flag, busy, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state: acc_out=%h out_valid=%b sat_flag=%b busy=%b in_ready=%b expected all 0",
                     acc_out, out_valid, sat_flag, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        terms_t t;
        t = '{22'd1, 22'd2, 22'd3, 22'd4};
        out_ready = 1'b1;
        run_burst(t, 0);
        collect("basic");
        expect_idle_after_handshake("basic");
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        terms_t t;
        out_ready = 1'b1;
        t = '{22'h1FFFFF, 22'h000001, 22'h3FFFFF, 22'h000000};
        run_burst(t, 0);
        collect("pos_sat");
        expect_idle_after_handshake("pos_sat");
        t = '{22'h200000, 22'h3FFFFF, 22'h000000, 22'h000000};
        run_burst(t, 0);
        collect("neg_sat");
        expect_idle_after_handshake("neg_sat");
        out_ready = 1'b0;
    endtask

    task automatic test_gaps_hold();
        terms_t t;
        t = '{22'd5, 22'd5, 22'd5, 22'd5};
        out_ready = 1'b0;
        run_burst(t, 3);
        collect("gaps");
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            cycle();
            checks++;
            if (out_valid !== 1'b1 || acc_out !== 22'd20 || busy !== 1'b1) begin
                errors++;
                $display("FAIL done_hold: cycle %0d out_valid=%b acc_out=%h busy=%b expected 1 %h 1",
                         i, out_valid, acc_out, busy, 22'd20);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        expect_idle_after_handshake("gaps");
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        terms_t t;
        bit     seen_valid = 0;
        do_start();
        drive_term(22'd7);
        drive_term(22'd8);
        in_data = 22'd9; in_valid = 1'b1; abort = 1'b1;
        cycle();
        in_valid = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b in_ready=%b out_valid=%b expected 0 0 0",
                     busy, in_ready, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (out_valid !== 1'b0) seen_valid = 1;
        end
        checks++;
        if (seen_valid || acc_out !== 22'd20) begin
            errors++;
            $display("FAIL abort_no_result: out_valid_seen=%b acc_out=%h expected 0 %h",
                     seen_valid, acc_out, 22'd20);
        end
        out_ready = 1'b1;
        t = '{22'd1, 22'd1, 22'd1, 22'd1};
        run_burst(t, 0);
        collect("after_abort");
        expect_idle_after_handshake("after_abort");
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_start();
        drive_term(22'h1FFFFF);
        drive_term(22'h000001);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({acc_out, out_valid, sat_flag, busy, in_ready} !== '0) begin
            errors++;
            $display("FAIL async_reset: acc_out=%h out_valid=%b sat_flag=%b busy=%b in_ready=%b expected all 0",
                     acc_out, out_valid, sat_flag, busy, in_ready);
        end
        #2 rst = 1'b0;
        cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        start = 1'b1;
        cycle();
        for (int i = 0; i < N_TERMS; i++) drive_term(22'd2);
        sb.push_back('{acc: 22'd8, sat: 1'b0});
        collect("b2b");
        cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b one cycle after handshake, expected 0", busy);
        end
        cycle();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rearm: in_ready=%b two cycles after handshake, expected 1", in_ready);
        end
        start = 1'b0;
        out_ready = 1'b0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_gaps_hold();
        test_abort();
        test_async_reset();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sat_accum_seq.md
Name: sat_accum_seq

Overview:
- Sequencer that time-shares one saturating adder to accumulate a burst of N_TERMS signed fixed-point samples into a single result.
- Accumulation saturates at every step, not only on the final sum.
- Sits between a sample producer (valid/ready) and a consumer (valid/ready), e.g. a filter tap-sum stage.
- Reports a sticky saturation flag per burst.

Parameters:
- W, 22: data width, two's complement signed.
- N_TERMS, 4: terms per burst, range 1 to 2^CW-1.
- CW, 3: term counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a new burst; honoured only in IDLE.
- abort  in  1  drop the current burst; honoured only in ACC.
- in_data  in  W  signed term.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a term.
- acc_out  out  W  signed burst result.
- out_valid  out  1  acc_out valid.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in ACC or DONE.
- sat_flag  out  1  some step of the current or last burst saturated.

Behaviour:
- Reset (async, immediate): state=IDLE, acc=0, cnt=0, acc_out=0, out_valid=0, sat_flag=0, busy=0, in_ready=0.
- States: IDLE, ACC, DONE.
- in_ready = (state==ACC), combinational from state.
- busy = (state!=IDLE).
- IDLE:
  - start=1 -> acc<=0, cnt<=0, sat_flag<=0, go to ACC.
  - abort is ignored.
- ACC, term accepted (in_valid && in_ready):
  - acc <= sat(acc+in_data).
  - sat_flag <= sat_flag | ovf.
  - cnt <= cnt+1.
- ACC, last term (cnt==N_TERMS-1 when accepted):
  - acc_out <= sat result, out_valid <= 1, go to DONE.
  - Latency: out_valid is high the cycle after the last accepted term.
- ACC, gaps: in_valid may drop for any number of cycles; acc and cnt hold.
- ACC, abort=1:
  - Go to IDLE; acc_out and out_valid unchanged (out_valid is 0).
  - abort wins over a term presented in the same cycle; that term is not accepted.
- DONE:
  - out_valid=1 and acc_out stay stable until out_ready=1.
  - On out_ready: out_valid <= 0, go to IDLE.
  - start and abort are ignored.
- acc_out and sat_flag hold their last values in IDLE until the next start.
- start is sampled as a level; holding it high re-arms immediately after DONE->IDLE. A new burst's first term can therefore be accepted 2 cycles after the out handshake.
- Saturation rules:
  - pos+pos with sign bit 1 -> 2^(W-1)-1 (0x1FFFFF for W=22).
  - neg+neg with sign bit 0 -> -2^(W-1) (0x200000 for W=22).
  - Mixed signs never saturate.
  - ovf = either saturation case.
- N_TERMS=1: a single accepted term goes straight to DONE.
- rst asserted in any state returns everything to reset values at once; the burst in progress is lost.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, ACC=2'd1, DONE=2'd2);
  - MAX_POS / MAX_NEG constant functions of W.
- One sub-module: the team's existing combinational saturating adder (Sumador, size=W, sign=1) computes sat(acc+in_data).
- ovf is derived in this block from the operand and result sign bits.
- FSM, counter and registers live in sat_accum_seq.

Test Plan (W=22, N_TERMS=4):
- start, then terms 1,2,3,4 back-to-back, out_ready=1 -> acc_out=10 one cycle after the 4th term, out_valid high 1 cycle, sat_flag=0.
- Terms 0x1FFFFF, 1, 0x3FFFFF(-1), 0 -> acc_out=0x1FFFFE, sat_flag=1. This proves per-step saturation.
- Terms 0x200000, 0x3FFFFF, 0, 0 -> acc_out=0x200000, sat_flag=1.
- Terms 5,5,5,5 with in_valid low 3 cycles between terms; out_ready low 5 cycles; start pulsed during DONE -> acc_out=20 stable, out_valid held 5+ cycles, start ignored; IDLE after out_ready.
- Two terms (7,8), then abort together with a valid third term -> IDLE, in_ready=0, out_valid never asserted. A new burst of 1,1,1,1 -> acc_out=4.
- rst asserted asynchronously mid-ACC after 2 terms -> acc_out, out_valid, sat_flag, busy and in_ready all 0 before the next clk edge.
